// File: rtl/axil_selftest_pkg.sv
// Shared types and constants for the AXI4-Lite self-test chip.
// Response codes, pattern constant, master state enum, counter helper.
package axil_selftest_pkg;

    localparam logic [1:0]  RESP_OKAY   = 2'b00;
    localparam logic [1:0]  RESP_SLVERR = 2'b10;
    localparam logic [15:0] PATTERN_HI  = 16'hCAFE;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_WR_REQ,
        ST_WR_RESP,
        ST_RD_REQ,
        ST_RD_RESP,
        ST_DONE
    } mst_state_t;

    function automatic logic [7:0] sat_inc(input logic [7:0] v);
        return (v == 8'hFF) ? v : v + 8'd1;
    endfunction

endpackage

// File: rtl/axil_mem_slave.sv
// AXI4-Lite slave memory with one-deep AW/W buffers.
// Out-of-range word accesses answer SLVERR; reads of them return 0.
module axil_mem_slave
    import axil_selftest_pkg::*;
#(
    parameter int ADDR_W    = 12,
    parameter int DATA_W    = 32,
    parameter int MEM_WORDS = 256
) (
    input  logic                aclk,
    input  logic                aresetn,
    input  logic [ADDR_W-1:0]   awaddr,
    input  logic                awvalid,
    output logic                awready,
    input  logic [DATA_W-1:0]   wdata,
    input  logic [DATA_W/8-1:0] wstrb,
    input  logic                wvalid,
    output logic                wready,
    output logic [1:0]          bresp,
    output logic                bvalid,
    input  logic                bready,
    input  logic [ADDR_W-1:0]   araddr,
    input  logic                arvalid,
    output logic                arready,
    output logic [DATA_W-1:0]   rdata,
    output logic [1:0]          rresp,
    output logic                rvalid,
    input  logic                rready
);

    localparam int WA_W  = ADDR_W - 2;
    localparam int IDX_W = $clog2(MEM_WORDS);

    logic [DATA_W-1:0]   mem [MEM_WORDS];

    logic                aw_full;
    logic                w_full;
    logic [WA_W-1:0]     aw_word;
    logic [DATA_W-1:0]   w_data;
    logic [DATA_W/8-1:0] w_strb;

    logic                aw_hs;
    logic                w_hs;
    logic                ar_hs;
    logic                b_free;
    logic                wr_fire;
    logic                wr_ok;
    logic                rd_ok;
    logic [WA_W-1:0]     wr_word;
    logic [WA_W-1:0]     rd_word;
    logic [DATA_W-1:0]   wr_data;
    logic [DATA_W/8-1:0] wr_strb;
    logic                unused_lsb;

    // READY flags come straight from state, never from VALID
    assign awready = !aw_full;
    assign wready  = !w_full;
    assign arready = !rvalid;

    assign aw_hs = awvalid && awready;
    assign w_hs  = wvalid && wready;
    assign ar_hs = arvalid && arready;

    // A write may retire the same cycle its last half arrives
    assign b_free  = !bvalid || bready;
    assign wr_word = aw_full ? aw_word : awaddr[ADDR_W-1:2];
    assign wr_data = w_full ? w_data : wdata;
    assign wr_strb = w_full ? w_strb : wstrb;
    assign wr_fire = (aw_full || aw_hs) && (w_full || w_hs) && b_free;
    assign wr_ok   = 32'(wr_word) < MEM_WORDS;

    assign rd_word = araddr[ADDR_W-1:2];
    assign rd_ok   = 32'(rd_word) < MEM_WORDS;

    assign unused_lsb = ^{awaddr[1:0], araddr[1:0]};

    // Hold an early AW or W until its partner arrives
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            aw_full <= 1'b0;
            w_full  <= 1'b0;
            aw_word <= '0;
            w_data  <= '0;
            w_strb  <= '0;
        end else if (wr_fire) begin
            aw_full <= 1'b0;
            w_full  <= 1'b0;
        end else begin
            if (aw_hs) begin
                aw_full <= 1'b1;
                aw_word <= awaddr[ADDR_W-1:2];
            end
            if (w_hs) begin
                w_full <= 1'b1;
                w_data <= wdata;
                w_strb <= wstrb;
            end
        end
    end

    // Byte-strobed storage, never reset
    always_ff @(posedge aclk) begin
        if (wr_fire && wr_ok) begin
            for (int b = 0; b < DATA_W/8; b++) begin
                if (wr_strb[b]) begin
                    mem[wr_word[IDX_W-1:0]][8*b +: 8] <= wr_data[8*b +: 8];
                end
            end
        end
    end

    // Write response, held until accepted
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            bvalid <= 1'b0;
            bresp  <= RESP_OKAY;
        end else if (wr_fire) begin
            bvalid <= 1'b1;
            bresp  <= wr_ok ? RESP_OKAY : RESP_SLVERR;
        end else if (bready) begin
            bvalid <= 1'b0;
        end
    end

    // Read response one cycle after AR, held until accepted
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            rvalid <= 1'b0;
            rdata  <= '0;
            rresp  <= RESP_OKAY;
        end else if (ar_hs) begin
            rvalid <= 1'b1;
            if (rd_ok) begin
                rdata <= mem[rd_word[IDX_W-1:0]];
                rresp <= RESP_OKAY;
            end else begin
                rdata <= '0;
                rresp <= RESP_SLVERR;
            end
        end else if (rready) begin
            rvalid <= 1'b0;
        end
    end

endmodule

// File: rtl/axil_selftest_chip.sv
// AXI4-Lite self-test chip: pattern master, memory slave, link monitor.
// Writes NUM_TXN words, reads them back, reports errors and counts.
module axil_selftest_chip
    import axil_selftest_pkg::*;
#(
    parameter int ADDR_W    = 12,
    parameter int DATA_W    = 32,
    parameter int MEM_WORDS = 256,
    parameter int BASE_ADDR = 0,
    parameter int NUM_TXN   = 16
) (
    input  logic       aclk,
    input  logic       aresetn,
    output logic       done,
    output logic       pass,
    output logic [7:0] err_cnt,
    output logic [7:0] wr_txn_cnt,
    output logic [7:0] rd_txn_cnt
);

    logic [ADDR_W-1:0]   awaddr;
    logic                awvalid;
    logic                awready;
    logic [DATA_W-1:0]   wdata;
    logic [DATA_W/8-1:0] wstrb;
    logic                wvalid;
    logic                wready;
    logic [1:0]          bresp;
    logic                bvalid;
    logic                bready;
    logic [ADDR_W-1:0]   araddr;
    logic                arvalid;
    logic                arready;
    logic [DATA_W-1:0]   rdata;
    logic [1:0]          rresp;
    logic                rvalid;
    logic                rready;

    mst_state_t        state;
    mst_state_t        state_next;
    logic [7:0]        idx;
    logic              idx_last;
    logic              aw_sent;
    logic              w_sent;
    logic              aw_hs;
    logic              w_hs;
    logic              b_hs;
    logic              r_hs;
    logic [ADDR_W-1:0] cur_addr;
    logic [DATA_W-1:0] cur_data;

    assign cur_addr = ADDR_W'(BASE_ADDR + 4 * int'(idx));
    assign cur_data = DATA_W'({PATTERN_HI, 8'h00, idx});
    assign idx_last = (idx == 8'(NUM_TXN - 1));

    assign awaddr = cur_addr;
    assign araddr = cur_addr;
    assign wdata  = cur_data;
    assign wstrb  = '1;

    assign aw_hs = awvalid && awready;
    assign w_hs  = wvalid && wready;
    assign b_hs  = bvalid && bready;
    assign r_hs  = rvalid && rready;

    assign done = (state == ST_DONE);
    assign pass = done && (err_cnt == 8'd0);

    // Master state register
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) state <= ST_IDLE;
        else          state <= state_next;
    end

    // Master next state and channel drives
    always_comb begin
        state_next = state;
        awvalid    = 1'b0;
        wvalid     = 1'b0;
        bready     = 1'b0;
        arvalid    = 1'b0;
        rready     = 1'b0;
        unique case (state)
            ST_IDLE: state_next = ST_WR_REQ;
            ST_WR_REQ: begin
                awvalid = !aw_sent;
                wvalid  = !w_sent;
                if ((aw_sent || aw_hs) && (w_sent || w_hs))
                    state_next = ST_WR_RESP;
            end
            ST_WR_RESP: begin
                bready = 1'b1;
                if (bvalid)
                    state_next = idx_last ? ST_RD_REQ : ST_WR_REQ;
            end
            ST_RD_REQ: begin
                arvalid = 1'b1;
                if (arready) state_next = ST_RD_RESP;
            end
            ST_RD_RESP: begin
                rready = 1'b1;
                if (rvalid)
                    state_next = idx_last ? ST_DONE : ST_RD_REQ;
            end
            ST_DONE: state_next = ST_DONE;
            default: state_next = ST_IDLE;
        endcase
    end

    // Transaction index, half-sent write flags and error count
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            idx     <= 8'd0;
            aw_sent <= 1'b0;
            w_sent  <= 1'b0;
            err_cnt <= 8'd0;
        end else begin
            if (state == ST_WR_REQ) begin
                if (state_next == ST_WR_RESP) begin
                    aw_sent <= 1'b0;
                    w_sent  <= 1'b0;
                end else begin
                    if (aw_hs) aw_sent <= 1'b1;
                    if (w_hs)  w_sent  <= 1'b1;
                end
            end
            if (b_hs) begin
                idx <= idx_last ? 8'd0 : idx + 8'd1;
                if (bresp != RESP_OKAY) err_cnt <= sat_inc(err_cnt);
            end
            if (r_hs) begin
                if (!idx_last) idx <= idx + 8'd1;
                if (rresp != RESP_OKAY || rdata != cur_data)
                    err_cnt <= sat_inc(err_cnt);
            end
        end
    end

    // Passive monitor of completed responses
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            wr_txn_cnt <= 8'd0;
            rd_txn_cnt <= 8'd0;
        end else begin
            if (b_hs) wr_txn_cnt <= sat_inc(wr_txn_cnt);
            if (r_hs) rd_txn_cnt <= sat_inc(rd_txn_cnt);
        end
    end

    axil_mem_slave #(
        .ADDR_W    (ADDR_W),
        .DATA_W    (DATA_W),
        .MEM_WORDS (MEM_WORDS)
    ) u_slave (
        .aclk    (aclk),
        .aresetn (aresetn),
        .awaddr  (awaddr),
        .awvalid (awvalid),
        .awready (awready),
        .wdata   (wdata),
        .wstrb   (wstrb),
        .wvalid  (wvalid),
        .wready  (wready),
        .bresp   (bresp),
        .bvalid  (bvalid),
        .bready  (bready),
        .araddr  (araddr),
        .arvalid (arvalid),
        .arready (arready),
        .rdata   (rdata),
        .rresp   (rresp),
        .rvalid  (rvalid),
        .rready  (rready)
    );

endmodule

// File: tb/tb_axil_selftest_chip.sv
// Bench for axil_selftest_chip: three parameterisations, random reset timing.
// Expected responses and counts come from a pattern/range model.
module tb_axil_selftest_chip;

    logic       clk;
    logic       r0, r1, r2;
    logic       d0_done, d0_pass, d1_done, d1_pass, d2_done, d2_pass;
    logic [7:0] d0_err, d0_wr, d0_rd;
    logic [7:0] d1_err, d1_wr, d1_rd;
    logic [7:0] d2_err, d2_wr, d2_rd;

    int compared   = 0;
    int mismatched = 0;
    int edges      = 0;
    int done_e0, done_e1, done_e2;
    int rb0, wb0, rb1, wb1;
    int hold, k;

    axil_selftest_chip dut0 (
        .aclk(clk), .aresetn(r0), .done(d0_done), .pass(d0_pass),
        .err_cnt(d0_err), .wr_txn_cnt(d0_wr), .rd_txn_cnt(d0_rd)
    );

    axil_selftest_chip #(.BASE_ADDR(1024), .NUM_TXN(4)) dut1 (
        .aclk(clk), .aresetn(r1), .done(d1_done), .pass(d1_pass),
        .err_cnt(d1_err), .wr_txn_cnt(d1_wr), .rd_txn_cnt(d1_rd)
    );

    axil_selftest_chip #(.NUM_TXN(1)) dut2 (
        .aclk(clk), .aresetn(r2), .done(d2_done), .pass(d2_pass),
        .err_cnt(d2_err), .wr_txn_cnt(d2_wr), .rd_txn_cnt(d2_rd)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic bit in_range(int base, int i, int words);
        return ((base + 4 * i) / 4) < words;
    endfunction

    function automatic logic [31:0] exp_data(int base, int i, int words);
        logic [15:0] lo;
        lo = 16'(i);
        return in_range(base, i, words) ? {16'hCAFE, lo} : 32'h0;
    endfunction

    function automatic logic [1:0] exp_resp(int base, int i, int words);
        return in_range(base, i, words) ? 2'b00 : 2'b10;
    endfunction

    function automatic int exp_errs(int base, int n, int words);
        int e = 0;
        for (int i = 0; i < n; i++)
            if (!in_range(base, i, words)) e += 2;
        return (e > 255) ? 255 : e;
    endfunction

    task automatic check(input string tag, input logic [31:0] obs,
                         input logic [31:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic clear_model0();
        edges   = 0;
        done_e0 = -1;
        rb0     = 0;
        wb0     = 0;
    endtask

    task automatic run_edges(input int limit);
        for (int e = 0; e < limit; e++) begin
            @(posedge clk);
            edges++;
            @(negedge clk);
            if (d0_done && done_e0 < 0) done_e0 = edges;
            if (d1_done && done_e1 < 0) done_e1 = edges;
            if (d2_done && done_e2 < 0) done_e2 = edges;
            if (dut0.bvalid && dut0.bready) begin
                check("d0_bresp", 32'(dut0.bresp), 32'(exp_resp(0, wb0, 256)));
                wb0++;
            end
            if (dut0.rvalid && dut0.rready) begin
                check("d0_rdata", dut0.rdata, exp_data(0, rb0, 256));
                if (rb0 == 3) begin
                    check("d0_beat3_data", dut0.rdata, 32'hCAFE0003);
                    check("d0_beat3_resp", 32'(dut0.rresp), 32'h0);
                end
                rb0++;
            end
            if (dut1.bvalid && dut1.bready) begin
                check("d1_bresp", 32'(dut1.bresp), 32'(exp_resp(1024, wb1, 256)));
                wb1++;
            end
            if (dut1.rvalid && dut1.rready) begin
                check("d1_rresp", 32'(dut1.rresp), 32'(exp_resp(1024, rb1, 256)));
                check("d1_rdata", dut1.rdata, exp_data(1024, rb1, 256));
                rb1++;
            end
            if (d0_done && d1_done && d2_done) break;
        end
    endtask

    initial begin
        r0 = 1'b0;
        r1 = 1'b0;
        r2 = 1'b0;
        done_e1 = -1;
        done_e2 = -1;
        rb1 = 0;
        wb1 = 0;
        clear_model0();

        hold = $urandom_range(5, 9);
        repeat (hold) @(negedge clk);
        check("rst_d0_done", 32'(d0_done), 32'h0);
        check("rst_d0_pass", 32'(d0_pass), 32'h0);
        check("rst_d0_cnts", {8'h0, d0_err, d0_wr, d0_rd}, 32'h0);
        check("rst_d1_cnts", {7'h0, d1_done, d1_err, d1_wr, d1_rd}, 32'h0);
        check("rst_d2_cnts", {7'h0, d2_done, d2_err, d2_wr, d2_rd}, 32'h0);
        check("rst_d0_avalid", 32'({dut0.awvalid, dut0.arvalid}), 32'h0);
        check("rst_d0_ready",
              32'({dut0.awready, dut0.wready, dut0.arready}), 32'h7);

        r0 = 1'b1;
        r1 = 1'b1;
        r2 = 1'b1;
        run_edges(200);

        check("d0_done_edge", 32'(done_e0 > 0 && done_e0 <= 4 * 16 + 4), 32'h1);
        check("d0_pass", 32'({d0_done, d0_pass}), 32'h3);
        check("d0_err", 32'(d0_err), 32'(exp_errs(0, 16, 256)));
        check("d0_wr", 32'(d0_wr), 32'd16);
        check("d0_rd", 32'(d0_rd), 32'd16);
        check("d1_done_edge", 32'(done_e1 > 0 && done_e1 <= 4 * 4 + 4), 32'h1);
        check("d1_pass", 32'({d1_done, d1_pass}), 32'h2);
        check("d1_err", 32'(d1_err), 32'(exp_errs(1024, 4, 256)));
        check("d1_cnts", 32'({d1_wr, d1_rd}), 32'h0404);
        check("d1_beats", 32'({8'(wb1), 8'(rb1)}), 32'h0404);
        check("d2_done_edge", 32'(done_e2 > 0 && done_e2 <= 4 * 1 + 4), 32'h1);
        check("d2_pass", 32'({d2_done, d2_pass}), 32'h3);
        check("d2_cnts", 32'({d2_err, d2_wr, d2_rd}), 32'h000101);

        r0 = 1'b0;
        repeat (2) @(negedge clk);
        r0 = 1'b1;
        clear_model0();
        k = $urandom_range(36, 62);
        run_edges(k);
        check("mid_d0_wr", 32'(d0_wr), 32'd16);
        check("mid_d0_rd", 32'(d0_rd), 32'((k - 1 - 2 * 16) / 2));
        check("mid_d0_done", 32'(d0_done), 32'h0);

        r0 = 1'b0;
        #1;
        check("pulse_d0_cnts", {7'h0, d0_done, d0_err, d0_wr, d0_rd}, 32'h0);
        check("pulse_d0_avalid", 32'({dut0.awvalid, dut0.arvalid}), 32'h0);
        @(negedge clk);
        r0 = 1'b1;
        clear_model0();
        run_edges(200);

        check("re_d0_done_edge", 32'(done_e0 > 0 && done_e0 <= 68), 32'h1);
        check("re_d0_pass", 32'({d0_done, d0_pass}), 32'h3);
        check("re_d0_cnts", 32'({d0_err, d0_wr, d0_rd}), 32'h001010);
        check("re_d0_beats", 32'({8'(wb0), 8'(rb0)}), 32'h1010);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 compared, mismatched);
        $finish;
    end

endmodule
